// File: rtl/sample_extract_pkg.sv
// Shared constants and types for the LWE sample-extraction block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ring/coefficient/modulus defaults, FSM state encoding, FIFO depth.
package sample_extract_pkg;

  // Shared ring parameters: coefficient width, log2 ring size, modulus.
  localparam int DATA_SIZE_ARB = 14;
  localparam int RING_DEPTH    = 10;
  localparam int MODULUS       = 12289;

  // Return-data buffer: 4 entries, 2-bit pointers.
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sample_extract_if.sv
// Bundle of the extractor's control, ACC-BRAM read and LWE output stream signals.
// Latency: n/a (wiring only).
// Backpressure: lwe_valid/lwe_ready handshake on the output stream.
// Ports: start/busy/done control, read_out/data_out BRAM read, lwe_* output beat.
interface sample_extract_if #(
  parameter int DLEN = 14,
  parameter int HLEN = 10
);
  logic            start;
  logic            busy;
  logic            done;
  logic [HLEN:0]   read_out;
  logic [DLEN-1:0] data_out;
  logic            lwe_valid;
  logic            lwe_ready;
  logic [DLEN-1:0] lwe_data;
  logic            lwe_last;

  // Extractor side.
  modport master (
    input  start, data_out, lwe_ready,
    output busy, done, read_out, lwe_valid, lwe_data, lwe_last
  );

  // Controller / BRAM / downstream side.
  modport slave (
    output start, data_out, lwe_ready,
    input  busy, done, read_out, lwe_valid, lwe_data, lwe_last
  );
endinterface

// File: rtl/sample_extract_skid_fifo.sv
// 4-entry synchronous FIFO holding returned BRAM words (data + last flag).
// Latency: write visible at the head one cycle later; read is combinational from the head.
// Backpressure: writes dropped when full, reads ignored when empty; caller reserves space.
// Ports: clk/reset, wr_en_i/wr_dat_i, rd_en_i/rd_dat_o, full_o/empty_o/count_o.
module skid_fifo
  import sample_extract_pkg::*;
#(
  parameter int W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [W-1:0]     wr_dat_i,
  input  logic             rd_en_i,
  output logic [W-1:0]     rd_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [FIFO_AW:0] count_o
);

  logic [W-1:0]       mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               do_wr, do_rd;

  assign full_o  = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
        2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sample_extract.sv
// Extracts an LWE sample (a-part negacyclically reversed and negated, then b[0]) from the ACC BRAM.
// Latency: first beat RD_LAT+2 cycles after start, then 1 beat/cycle; done RD_LAT+3+N after start.
// Backpressure: lwe_ready stalls output; reads are throttled so FIFO + in-flight never exceeds 4.
// Ports: clk, reset (async, active high), bus (sample_extract_if.master).
module sample_extract
  import sample_extract_pkg::*;
#(
  parameter int DLEN   = DATA_SIZE_ARB,
  parameter int HLEN   = RING_DEPTH,
  parameter int Q      = MODULUS,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  sample_extract_if.master  bus
);

  localparam int            N        = 1 << HLEN;
  localparam logic [HLEN:0] LAST_IDX = (HLEN+1)'(N);
  localparam logic [DLEN-1:0] QV     = DLEN'(Q);

  state_e state_q, state_d;

  // Beat index of the next read to issue, 0..N.
  logic [HLEN:0] iss_cnt_q, iss_cnt_d;

  // Read-return pipeline: valid, negate-on-return and last flags travel with each read.
  logic [RD_LAT-1:0] pend_q, pneg_q, plast_q;

  logic              issue;
  logic [7:0]        inflight;
  logic              room;
  logic [HLEN-1:0]   rd_idx;
  logic              iss_neg, iss_last;

  logic              fifo_full, fifo_empty;
  logic [FIFO_AW:0]  fifo_cnt;
  logic [DLEN:0]     fifo_wdat, fifo_rdat;
  logic [DLEN-1:0]   ret_dat;
  logic              pop;

  // Reads in flight = set bits of the return pipeline.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      inflight = inflight + {7'd0, pend_q[k]};
    end
  end

  // Each issued read has a guaranteed FIFO slot when its data returns.
  assign room = (({5'd0, fifo_cnt} + inflight) < 8'(FIFO_DEPTH)) && !fifo_full;

  // Beat i reads a[(N-i) mod N]; beat N has bit HLEN set and index 0, i.e. b[0].
  assign rd_idx   = '0 - iss_cnt_q[HLEN-1:0];
  assign iss_last = iss_cnt_q[HLEN];
  assign iss_neg  = (iss_cnt_q != '0) && !iss_cnt_q[HLEN];

  always_comb begin
    state_d   = state_q;
    iss_cnt_d = iss_cnt_q;
    issue     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_ISSUE;
          iss_cnt_d = '0;
        end
      end
      ST_ISSUE: begin
        if (room) begin
          issue     = 1'b1;
          iss_cnt_d = iss_cnt_q + (HLEN+1)'(1);
          if (iss_cnt_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && fifo_rdat[DLEN]) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      iss_cnt_q <= '0;
      pend_q    <= '0;
      pneg_q    <= '0;
      plast_q   <= '0;
    end else begin
      state_q   <= state_d;
      iss_cnt_q <= iss_cnt_d;
      // Shift towards the MSB; the MSB marks data_out valid this cycle.
      pend_q    <= RD_LAT'({pend_q, issue});
      pneg_q    <= RD_LAT'({pneg_q, iss_neg});
      plast_q   <= RD_LAT'({plast_q, iss_last});
    end
  end

  // Negation mod Q keeps zero at zero so the result stays below Q.
  assign ret_dat   = (pneg_q[RD_LAT-1] && (bus.data_out != '0)) ? (QV - bus.data_out)
                   : (pneg_q[RD_LAT-1] ? '0 : bus.data_out);
  assign fifo_wdat = {plast_q[RD_LAT-1], ret_dat};

  skid_fifo #(.W(DLEN+1)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (pend_q[RD_LAT-1]),
    .wr_dat_i (fifo_wdat),
    .rd_en_i  (pop),
    .rd_dat_o (fifo_rdat),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_cnt)
  );

  assign pop           = !fifo_empty && bus.lwe_ready;
  assign bus.lwe_valid = !fifo_empty;
  assign bus.lwe_data  = fifo_rdat[DLEN-1:0];
  assign bus.lwe_last  = fifo_rdat[DLEN];
  assign bus.read_out  = issue ? {iss_last, rd_idx} : '0;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sample_extract.sv
// Bench for sample_extract: ACC BRAM model, scenario table plus reset/stall sequences.
// Latency: n/a.
// Backpressure: drives lwe_ready patterns (always-on, toggling, long stall).
module tb_sample_extract;
  import sample_extract_pkg::*;

  localparam int DLEN   = 14;
  localparam int HLEN   = 10;
  localparam int N      = 1 << HLEN;
  localparam int Q      = 12289;
  localparam int RD_LAT = 2;

  logic clk;
  logic reset;
  int   cyc;

  sample_extract_if #(.DLEN(DLEN), .HLEN(HLEN)) bus ();

  sample_extract #(.DLEN(DLEN), .HLEN(HLEN), .Q(Q), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ACC BRAM model: a[k] at {0,k}, b[k] at {1,k}; two-cycle read latency.
  logic [DLEN-1:0] mem [0:2*N-1];
  logic [DLEN-1:0] rp1, rp2;
  always @(posedge clk) begin
    rp1 <= mem[bus.read_out];
    rp2 <= rp1;
  end
  assign bus.data_out = rp2;

  int n_chk, n_fail;

  // Monitor state (only the main initial process touches these).
  logic [DLEN-1:0] got_d[$];
  logic            got_l[$];
  int              done_cnt, done_cyc, first_valid, nz_reads, valid_seen;
  logic            hold_prev;
  logic [DLEN-1:0] prev_d;
  logic            prev_l;

  typedef struct {
    int mode;       // 0 ready=1, 1 toggle, 2 stall 50 cycles
    int zero_a;     // 1: a[N-1] forced to 0
    int b0;
    int x0;         // extra start offsets (-1 none)
    int x1;
    int valid_off;  // expected first lwe_valid offset (-1 skip)
    int done_off;   // expected done offset (-1 skip)
    int beat1;      // hand-computed beat 1
    int lastv;      // hand-computed final beat
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int exp_word(input int i);
    logic [DLEN-1:0] x;
    logic [DLEN-1:0] qv;
    qv = DLEN'(Q);
    if (i == 0) return int'({1'b0, mem[0]});
    if (i == N) return int'({1'b1, mem[N]});
    x = mem[N-i];
    if (x == '0) return 0;
    return int'({1'b0, qv - x});
  endfunction

  function automatic logic ready_val(input int mode, input int k);
    if (mode == 1) return (k % 2) == 0;
    if (mode == 2) return k >= 50;
    return 1'b1;
  endfunction

  task automatic sample();
    if (hold_prev) begin
      n_chk++;
      if (!(bus.lwe_valid && bus.lwe_data == prev_d && bus.lwe_last == prev_l)) begin
        n_fail++;
        $display("FAIL hold_stable cyc=%0d got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                 cyc, bus.lwe_valid, bus.lwe_data, bus.lwe_last, prev_d, prev_l);
      end
    end
    if (bus.lwe_valid) valid_seen++;
    if (bus.lwe_valid && first_valid < 0) first_valid = cyc;
    if (bus.lwe_valid && bus.lwe_ready) begin
      got_d.push_back(bus.lwe_data);
      got_l.push_back(bus.lwe_last);
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.read_out != '0) nz_reads++;
    hold_prev = bus.lwe_valid && !bus.lwe_ready;
    prev_d    = bus.lwe_data;
    prev_l    = bus.lwe_last;
  endtask

  task automatic clear_mon();
    got_d.delete();
    got_l.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    first_valid = -1;
    nz_reads    = 0;
    valid_seen  = 0;
    hold_prev   = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_beats"}, got_d.size(), N + 1);
    for (int i = 0; i <= N && i < got_d.size(); i++) begin
      chk($sformatf("%s_beat%0d", tag, i), int'({got_l[i], got_d[i]}), exp_word(i));
    end
  endtask

  task automatic run_stream(input vec_t v, input string tag);
    int t0;
    int k;
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc;
    bus.start     = 1'b1;
    bus.lwe_ready = ready_val(v.mode, 0);
    @(negedge clk); sample();
    k = 0;
    while (done_cnt == 0 && k < 5000) begin
      k++;
      @(posedge clk); #1;
      bus.start     = (k == v.x0) || (k == v.x1);
      bus.lwe_ready = ready_val(v.mode, k);
      @(negedge clk); sample();
      if (v.mode == 2 && k == 49) begin
        chk({tag, "_stall_reads_max4"}, int'(nz_reads <= 3), 1);
        chk({tag, "_stall_valid"}, int'(bus.lwe_valid), 1);
        chk({tag, "_stall_beat0"}, int'({bus.lwe_last, bus.lwe_data}), exp_word(0));
        chk({tag, "_stall_no_xfer"}, got_d.size(), 0);
      end
    end
    if (done_cnt == 0) chk({tag, "_timeout_done"}, 0, 1);
    for (int p = 0; p < 6; p++) begin
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.lwe_ready = 1'b1;
      @(negedge clk); sample();
      if (p == 0) chk({tag, "_idle_after_done"}, int'(bus.busy), 0);
    end
    chk({tag, "_done_pulses"}, done_cnt, 1);
    if (v.valid_off >= 0) chk({tag, "_first_valid_cyc"}, first_valid - t0, v.valid_off);
    if (v.done_off >= 0)  chk({tag, "_done_cyc"}, done_cyc - t0, v.done_off);
    if (got_d.size() > 1) chk({tag, "_beat1_hand"}, int'(got_d[1]), v.beat1);
    if (got_d.size() > N) chk({tag, "_last_hand"}, int'({got_l[N], got_d[N]}), (1 << DLEN) | v.lastv);
    check_stream(tag);
  endtask

  initial begin
    int k;
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < N; i++) begin
      mem[i]     = DLEN'(i);
      mem[N + i] = DLEN'(5000 + i);
    end
    //            mode zero b0     x0   x1    vo  done  beat1  last
    vecs[0] = '{0,   0,   77,    -1,  -1,   4,  1029, 11266, 77};
    vecs[1] = '{0,   1,   77,    -1,  -1,   4,  1029, 0,     77};
    vecs[2] = '{1,   0,   77,    -1,  -1,   -1, -1,   11266, 77};
    vecs[3] = '{0,   0,   12288, 100, 1029, 4,  1029, 11266, 12288};
    vecs[4] = '{2,   0,   77,    -1,  -1,   -1, -1,   11266, 77};

    clear_mon();
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.lwe_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",    int'(bus.lwe_valid), 0);
    chk("rst_busy",     int'(bus.busy), 0);
    chk("rst_done",     int'(bus.done), 0);
    chk("rst_read_out", int'(bus.read_out), 0);
    chk("rst_data",     int'(bus.lwe_data), 0);
    chk("rst_last",     int'(bus.lwe_last), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 5; v++) begin
      mem[N]     = DLEN'(vecs[v].b0);
      mem[N - 1] = (vecs[v].zero_a != 0) ? '0 : DLEN'(N - 1);
      run_stream(vecs[v], $sformatf("vec%0d", v));
    end
    mem[N]     = DLEN'(77);
    mem[N - 1] = DLEN'(N - 1);

    // Reset in the middle of the stream, right after beat 300 is taken.
    clear_mon();
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.lwe_ready = 1'b1;
    @(negedge clk); sample();
    k = 0;
    while (got_d.size() < 300 && k < 2000) begin
      k++;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk); sample();
    end
    chk("mid_reset_reach300", got_d.size(), 300);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_reset_valid",    int'(bus.lwe_valid), 0);
    chk("mid_reset_busy",     int'(bus.busy), 0);
    chk("mid_reset_done",     int'(bus.done), 0);
    chk("mid_reset_read_out", int'(bus.read_out), 0);
    chk("mid_reset_data",     int'(bus.lwe_data), 0);
    chk("mid_reset_last",     int'(bus.lwe_last), 0);
    hold_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    valid_seen = 0;
    for (int p = 0; p < 20; p++) begin
      @(posedge clk); #1;
      bus.lwe_ready = 1'b1;
      @(negedge clk); sample();
    end
    chk("post_reset_no_beats", got_d.size(), 300);
    chk("post_reset_no_valid", valid_seen, 0);
    chk("post_reset_no_done",  done_cnt, 0);
    chk("post_reset_idle",     int'(bus.busy), 0);

    run_stream(vecs[0], "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
